// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: port IDs and lock FSM encodings.
package dmem_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam logic        PORT_CPU  = 1'b0;
  localparam logic        PORT_DBG  = 1'b1;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin pick; ptr names the port that wins a tie.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 ptr,
  output logic [NUM_PORTS-1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = (ptr == PORT_DBG) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of the 1-cycle-latency data memory.
// Optional atomic lock support is compiled in with DMEM_ARB_LOCK_EN.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_A_WIDTH = 8,
  parameter int unsigned D_WIDTH     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_req,
  input  logic               p0_we,
  input  logic [31:0]        p0_addr,
  input  logic [D_WIDTH-1:0] p0_wdata,
  output logic               p0_gnt,
  output logic               p0_rvalid,
  output logic [D_WIDTH-1:0] p0_rdata,
  output logic               p0_err,
  input  logic               p1_req,
  input  logic               p1_we,
  input  logic [31:0]        p1_addr,
  input  logic [D_WIDTH-1:0] p1_wdata,
  output logic               p1_gnt,
  output logic               p1_rvalid,
  output logic [D_WIDTH-1:0] p1_rdata,
  output logic               p1_err,
`ifdef DMEM_ARB_LOCK_EN
  input  logic               p0_lock,
  input  logic               p1_lock,
`endif
  output logic               mem_we,
  output logic [31:0]        mem_w_addr,
  output logic [D_WIDTH-1:0] mem_w_data,
  output logic               mem_re,
  output logic [31:0]        mem_r_addr,
  input  logic [D_WIDTH-1:0] mem_r_data
);

  logic [NUM_PORTS-1:0] req, req_eff, gnt;
  logic                 rr_ptr_q, rr_ptr_d;
  logic                 winner, granted, sel_we, addr_bad, issue;
  logic [31:0]          sel_addr;
  logic [D_WIDTH-1:0]   sel_wdata;
  logic                 rd_pend_q, rd_pend_d, rd_tag_q, rd_tag_d;
  logic [NUM_PORTS-1:0] err_q, err_d;
  logic [D_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  assign req = {p1_req, p0_req};

`ifdef DMEM_ARB_LOCK_EN
  lock_state_e lock_q, lock_d;
  logic        lock_owner_q, lock_owner_d;
  logic        sel_lock;

  // While locked, only the owner's request is visible to the picker.
  always_comb begin
    req_eff = req;
    if (lock_q == LK_LOCKED) begin
      req_eff = req & ((lock_owner_q == PORT_DBG) ? 2'b10 : 2'b01);
    end
  end

  assign sel_lock = winner ? p1_lock : p0_lock;

  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (granted) begin
      if ((lock_q == LK_UNLOCKED) && sel_lock) begin
        lock_d       = LK_LOCKED;
        lock_owner_d = winner;
      end else if ((lock_q == LK_LOCKED) && !sel_lock) begin
        lock_d = LK_UNLOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q       <= LK_UNLOCKED;
      lock_owner_q <= PORT_CPU;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`else
  assign req_eff = req;
`endif

  rr_pick2 u_pick (
    .req (req_eff),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign granted   = |gnt;
  assign winner    = gnt[PORT_DBG];
  assign p0_gnt    = gnt[PORT_CPU];
  assign p1_gnt    = gnt[PORT_DBG];
  assign sel_we    = winner ? p1_we    : p0_we;
  assign sel_addr  = winner ? p1_addr  : p0_addr;
  assign sel_wdata = winner ? p1_wdata : p0_wdata;
  assign addr_bad  = (sel_addr[1:0] != 2'b00) || (sel_addr[31:MEM_A_WIDTH+2] != '0);
  assign issue     = granted && !addr_bad;

  assign p0_rvalid = rd_pend_q && (rd_tag_q == PORT_CPU);
  assign p1_rvalid = rd_pend_q && (rd_tag_q == PORT_DBG);
  assign p0_rdata  = p0_rvalid ? mem_r_data : rdata0_q;
  assign p1_rdata  = p1_rvalid ? mem_r_data : rdata1_q;
  assign p0_err    = err_q[PORT_CPU];
  assign p1_err    = err_q[PORT_DBG];

  always_comb begin
    mem_we     = issue && sel_we;
    mem_re     = issue && !sel_we;
    mem_w_addr = mem_we ? sel_addr  : '0;
    mem_w_data = mem_we ? sel_wdata : '0;
    mem_r_addr = mem_re ? sel_addr  : '0;
    rr_ptr_d   = granted ? ~winner : rr_ptr_q;
    rd_pend_d  = mem_re;
    rd_tag_d   = mem_re ? winner : rd_tag_q;
    err_d      = '0;
    if (granted && addr_bad) begin
      err_d[winner] = 1'b1;
    end
    // Response data is captured so rdata holds once rvalid drops.
    rdata0_d   = p0_rvalid ? mem_r_data : rdata0_q;
    rdata1_d   = p1_rvalid ? mem_r_data : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q  <= PORT_CPU;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= PORT_CPU;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized self-checking bench for data_mem_arbiter with a behavioural memory and
// a transaction-level reference model (default build, lock feature off).
module tb_data_mem_arbiter;

  localparam int unsigned MemAWidth = 8;
  localparam int unsigned Words     = 1 << MemAWidth;

  logic        clk, rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_w_addr, mem_w_data, mem_r_addr, mem_r_data;

  data_mem_arbiter #(
    .MEM_A_WIDTH (MemAWidth),
    .D_WIDTH     (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p0_req     (p0_req),
    .p0_we      (p0_we),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p0_gnt     (p0_gnt),
    .p0_rvalid  (p0_rvalid),
    .p0_rdata   (p0_rdata),
    .p0_err     (p0_err),
    .p1_req     (p1_req),
    .p1_we      (p1_we),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p1_gnt     (p1_gnt),
    .p1_rvalid  (p1_rvalid),
    .p1_rdata   (p1_rdata),
    .p1_err     (p1_err),
`ifdef DMEM_ARB_LOCK_EN
    .p0_lock    (1'b0),
    .p1_lock    (1'b0),
`endif
    .mem_we     (mem_we),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_re     (mem_re),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Behavioural memory: 1-cycle read latency, write-through, garbage when not reading.
  logic [31:0] mem_arr [Words];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(Words); i++) mem_arr[i] <= seed_word(i);
      mem_r_data <= 32'h0;
    end else begin
      if (mem_we) mem_arr[mem_w_addr[MemAWidth+1:2]] <= mem_w_data;
      if (mem_re) begin
        if (mem_we && mem_w_addr == mem_r_addr) mem_r_data <= mem_w_data;
        else mem_r_data <= mem_arr[mem_r_addr[MemAWidth+1:2]];
      end else begin
        mem_r_data <= $urandom;
      end
    end
  end

  int unsigned n_checks, n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model state: held requests, memory image, expected responses.
  logic [1:0]  rq_req, rq_we;
  logic [31:0] rq_addr [2];
  logic [31:0] rq_wdata [2];
  logic [31:0] ref_mem [Words];
  logic [1:0]  exp_rv, exp_err;
  logic [31:0] exp_rdata [2];
  logic        pref;

  task automatic model_reset();
    exp_rv       = 2'b00;
    exp_err      = 2'b00;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    pref         = 1'b0;
    rq_req       = 2'b00;
  endtask

  // One clock cycle: drive held requests, check outputs mid-cycle, advance the model.
  task automatic step();
    logic        any, w, bad, wr, rd;
    logic [31:0] a;
    p0_req = rq_req[0]; p0_we = rq_we[0]; p0_addr = rq_addr[0]; p0_wdata = rq_wdata[0];
    p1_req = rq_req[1]; p1_we = rq_we[1]; p1_addr = rq_addr[1]; p1_wdata = rq_wdata[1];
    @(negedge clk);
    check_eq("p0_rvalid", 32'(p0_rvalid), 32'(exp_rv[0]));
    check_eq("p1_rvalid", 32'(p1_rvalid), 32'(exp_rv[1]));
    check_eq("p0_rdata", p0_rdata, exp_rdata[0]);
    check_eq("p1_rdata", p1_rdata, exp_rdata[1]);
    check_eq("p0_err", 32'(p0_err), 32'(exp_err[0]));
    check_eq("p1_err", 32'(p1_err), 32'(exp_err[1]));
    any = |rq_req;
    w   = (&rq_req) ? pref : rq_req[1];
    a   = rq_addr[w];
    bad = (a % 4 != 0) || (a >= 4 * Words);
    wr  = any && !bad && rq_we[w];
    rd  = any && !bad && !rq_we[w];
    check_eq("p0_gnt", 32'(p0_gnt), 32'(any && !w));
    check_eq("p1_gnt", 32'(p1_gnt), 32'(any && w));
    check_eq("mem_we", 32'(mem_we), 32'(wr));
    check_eq("mem_re", 32'(mem_re), 32'(rd));
    check_eq("mem_w_addr", mem_w_addr, wr ? a : 32'h0);
    check_eq("mem_w_data", mem_w_data, wr ? rq_wdata[w] : 32'h0);
    check_eq("mem_r_addr", mem_r_addr, rd ? a : 32'h0);
    exp_rv  = 2'b00;
    exp_err = 2'b00;
    if (any) begin
      pref = ~w;
      rq_req[w] = 1'b0;
      if (bad) exp_err[w] = 1'b1;
      else if (wr) ref_mem[a / 4] = rq_wdata[w];
      else begin
        exp_rv[w]    = 1'b1;
        exp_rdata[w] = ref_mem[a / 4];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    rq_req[p]   = 1'b1;
    rq_we[p]    = we;
    rq_addr[p]  = addr;
    rq_wdata[p] = wdata;
  endtask

  task automatic apply_reset();
    rq_req = 2'b00;
    p0_req = 1'b0;
    p1_req = 1'b0;
    rst    = 1'b0;
    #1;
    check_eq("rst_p0_rvalid", 32'(p0_rvalid), 32'h0);
    check_eq("rst_p1_rvalid", 32'(p1_rvalid), 32'h0);
    check_eq("rst_p0_rdata", p0_rdata, 32'h0);
    check_eq("rst_p1_rdata", p1_rdata, 32'h0);
    check_eq("rst_err", 32'({p1_err, p0_err}), 32'h0);
    check_eq("rst_mem_en", 32'({mem_we, mem_re}), 32'h0);
    check_eq("rst_gnt", 32'({p1_gnt, p0_gnt}), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ra;
  int unsigned r;

  initial begin
    n_checks = 0;
    n_errors = 0;
    mem_init = 1'b1;
    rst      = 1'b0;
    rq_we    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rq_addr[i]  = 32'h0;
      rq_wdata[i] = 32'h0;
    end
    p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    for (int i = 0; i < int'(Words); i++) ref_mem[i] = seed_word(i);
    @(posedge clk);
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    apply_reset();

    // Solo write then read-back.
    set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    step();
    set_req(0, 1'b0, 32'h10, 32'h0);
    step();
    check_eq("solo_rvalid", 32'(p0_rvalid), 32'h1);
    check_eq("solo_rdata", p0_rdata, 32'hDEAD_BEEF);
    step();

    // Contention from reset: alternate p0, p1, p0, p1.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      if (!rq_req[0]) set_req(0, 1'b0, 32'(i * 8), 32'h0);
      if (!rq_req[1]) set_req(1, 1'b0, 32'(i * 8 + 4), 32'h0);
      check_eq("cont_winner", 32'(pref), 32'(i % 2));
      step();
    end
    rq_req = 2'b00;
    step();

    // Back-to-back p1 reads.
    for (int i = 0; i < 3; i++) begin
      set_req(1, 1'b0, 32'(i * 4), 32'h0);
      step();
    end
    step();

    // Misaligned and out-of-range reads.
    set_req(0, 1'b0, 32'h3, 32'h0);
    step();
    set_req(0, 1'b0, 32'h400, 32'h0);
    step();
    step();

    // Randomized traffic with held requests.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq_req[p] && $urandom_range(3, 0) != 0) begin
          r = $urandom_range(15, 0);
          if (r == 0) ra = ($urandom_range(63, 0) << 2) | $urandom_range(3, 1);
          else if (r == 1) ra = 32'h400 + ($urandom_range(1023, 0) << 2);
          else if (r == 2) ra = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
          else ra = $urandom_range(63, 0) << 2;
          set_req(p, 1'($urandom_range(1, 0)), ra, $urandom);
        end
      end
      step();
    end
    rq_req = 2'b00;
    step();

    // Reset in the cycle after a read grant drops the response and re-arms p0 priority.
    set_req(1, 1'b0, 32'h40, 32'h0);
    step();
    set_req(0, 1'b0, 32'h44, 32'h0);
    step();
    apply_reset();
    set_req(0, 1'b0, 32'h48, 32'h0);
    set_req(1, 1'b0, 32'h4C, 32'h0);
    step();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-requester arbiter in front of the clocked data memory (1-cycle read latency, write-through on same-address read/write, word-indexed by addr[MEM_A_WIDTH+1:2]).
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
- Issues at most one memory operation per cycle, using round-robin arbitration, and routes each read response back to its issuer.

Parameters:
- MEM_A_WIDTH, 8, word-index width of the memory; used for the range check.
- D_WIDTH, 32, data width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- p0_req  input  1  port 0 request valid.
- p0_we  input  1  port 0 write (1) / read (0).
- p0_addr  input  32  port 0 byte address.
- p0_wdata  input  D_WIDTH  port 0 write data.
- p0_gnt  output  1  port 0 request accepted this cycle.
- p0_rvalid  output  1  port 0 read data valid.
- p0_rdata  output  D_WIDTH  port 0 read data.
- p0_err  output  1  port 0 access rejected (out of range or misaligned).
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1.
- mem_we  output  1  memory write enable.
- mem_w_addr  output  32  memory write address.
- mem_w_data  output  D_WIDTH  memory write data.
- mem_re  output  1  memory read enable.
- mem_r_addr  output  32  memory read address.
- mem_r_data  input  D_WIDTH  memory read data (valid the cycle after mem_re).

Behaviour:
- Reset (rst low, async):
  - All gnt, rvalid, err, mem_we and mem_re = 0; all rdata = 0.
  - rr_ptr = 0 (port 0 has priority first).
  - rd_pend = 0; rd_tag = 0; lock state = UNLOCKED.
- Request rule:
  - A port holds req, we, addr and wdata stable until it sees gnt.
  - gnt is combinational in the same cycle: a request is accepted on any cycle where req && gnt.
- Arbitration:
  - If only one port requests, it wins.
  - If both request, the port selected by rr_ptr wins.
  - After each grant, rr_ptr <= ~winner.
  - Exactly one gnt per cycle at most.
- Range check:
  - Error if addr[1:0] != 0, or if addr[31:MEM_A_WIDTH+2] != 0.
  - A failing request is still granted, but no memory operation is issued.
  - p*_err pulses 1 cycle later, for one cycle. No rvalid is produced for it.
- Write grant: mem_we = 1, mem_w_addr = addr, mem_w_data = wdata, in the same cycle (combinational pass-through).
- Read grant:
  - mem_re = 1 and mem_r_addr = addr in the same cycle.
  - rd_pend <= 1; rd_tag <= winner.
  - Next cycle: p[rd_tag]_rvalid = 1 and p[rd_tag]_rdata = mem_r_data.
  - rdata holds its last value when rvalid = 0.
- Latency: read data arrives at grant + 1 cycle. Fully pipelined, so back-to-back grants every cycle are allowed.
- Simultaneous read response and new grant: both happen in the same cycle, with no bubble.
- Idle: mem_we = mem_re = 0, and mem addresses/data are driven 0.
- Reset mid-operation: any pending read is dropped (no rvalid after reset deasserts), and rr_ptr returns to 0.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- When defined:
  - Adds input p0_lock and input p1_lock (1 bit each).
  - A granted request with p*_lock = 1 moves the lock FSM from UNLOCKED to LOCKED(owner).
  - While LOCKED, only the owner can be granted; the other port is stalled.
  - The lock releases (LOCKED -> UNLOCKED) on the owner's next granted request that has lock = 0.
  - Reset forces UNLOCKED.
  - This gives atomic read-modify-write.
- When undefined:
  - No lock ports and no lock FSM.
  - Arbitration is pure round-robin.

Decomposition:
- Shared package dmem_arb_pkg contains:
  - NUM_PORTS = 2.
  - Port ID constants PORT_CPU = 0 and PORT_DBG = 1.
  - Lock state encodings LK_UNLOCKED and LK_LOCKED.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin pick. It takes req[1:0] and ptr and returns a one-hot gnt[1:0]. The rr_ptr register lives in the parent.

Test Plan:
- Solo write then read: p0 writes 0xDEADBEEF to 0x10, then reads 0x10 → p0_gnt is 1 each cycle; mem_we, then mem_re; p0_rvalid = 1 one cycle after the read grant, with p0_rdata = 0xDEADBEEF.
- Contention: p0 and p1 both hold read requests for 4 cycles from reset → grants go p0, p1, p0, p1; each rvalid appears on the matching port 1 cycle later.
- Back-to-back reads: p1 reads 0x0, 0x4, 0x8 on consecutive cycles → three consecutive rvalid cycles in order, no bubbles, and p0_rvalid stays 0.
- Error cases: p0 reads 0x3 (misaligned), and with MEM_A_WIDTH = 8 reads 0x400 (out of range) → gnt = 1, mem_re = 0, p0_err pulses 1 cycle later, and no rvalid.
- Reset mid-read: assert rst low in the cycle after a read grant → p0_rvalid stays 0 through and after reset, and rr_ptr = 0 (p0 wins the next contention).
- DMEM_ARB_LOCK_EN: p1 reads 0x20 with lock = 1 while p0 requests continuously → p0 gets no gnt until p1 writes 0x20 with lock = 0; p0 is granted on the next cycle.
